// File: rtl/poci_pkg.sv
// poci_pkg: shared types, constants and bit-order helper for the POCI readback path
package poci_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int RESERVED_ADDR = 0;

    // Source bit of a word that is shifted out in serial position i
    function automatic int bit_pos(input int i, input int w, input bit lsb_first);
        return lsb_first ? i : w - 1 - i;
    endfunction

endpackage

// File: rtl/poci_reg_mux.sv
// poci_reg_mux: register-bank address decode; reserved or out-of-range addresses read as zero
module poci_reg_mux
    import poci_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 59,
    parameter int ADDR_W   = 8
) (
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    input  logic [ADDR_W-1:0]          addr,
    output logic [DATA_W-1:0]          data,
    output logic                       invalid
);

    always_comb begin
        invalid = addr == ADDR_W'(RESERVED_ADDR) || addr > ADDR_W'(NUM_REGS);
        data    = '0;
        for (int i = 1; i <= NUM_REGS; i++)
            if (addr == ADDR_W'(i)) data = regs_flat[(i-1)*DATA_W +: DATA_W];
    end

endmodule

// File: rtl/poci_burst_serializer.sv
// poci_burst_serializer: selects registers by address and shifts them out as gapless serial bursts
module poci_burst_serializer
    import poci_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_REGS  = 59,
    parameter int ADDR_W    = 8,
    parameter int LEN_W     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                       sclk,
    input  logic                       rst,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          start_addr,
    input  logic [LEN_W-1:0]           burst_len,
    output logic                       busy,
    output logic                       serial_out,
    output logic                       word_done,
    output logic                       frame_done,
    output logic                       addr_err
);

    state_t              state;
    logic [DATA_W-1:0]   shadow;
    logic [DATA_W-1:0]   mux_data;
    logic [DATA_W-1:0]   mux_ord;
    logic [DATA_W-1:0]   bit_cnt;
    logic [LEN_W:0]      words_left;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   next_addr;
    logic [ADDR_W-1:0]   sel_addr;
    logic                mux_invalid;
    logic                last_bit;
    logic                last_word;

    // Wrap past the top of the bank (or from an invalid start) always lands on address 1
    assign next_addr = addr >= ADDR_W'(NUM_REGS) ? ADDR_W'(1) : addr + ADDR_W'(1);
    assign sel_addr  = state == IDLE ? start_addr : next_addr;
    assign last_bit  = bit_cnt == DATA_W'(DATA_W - 1);
    assign last_word = words_left == (LEN_W+1)'(1);

    poci_reg_mux #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_mux (
        .regs_flat (regs_flat),
        .addr      (sel_addr),
        .data      (mux_data),
        .invalid   (mux_invalid)
    );

    // Shadow holds the word pre-ordered so the next serial bit is always shadow[0]
    for (genvar g = 0; g < DATA_W; g++) begin : g_ord
        assign mux_ord[g] = mux_data[bit_pos(g, DATA_W, LSB_FIRST)];
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state      <= IDLE;
            shadow     <= '0;
            bit_cnt    <= '0;
            words_left <= '0;
            addr       <= '0;
            busy       <= 1'b0;
            serial_out <= 1'b0;
            word_done  <= 1'b0;
            frame_done <= 1'b0;
            addr_err   <= 1'b0;
        end else if (state == IDLE) begin
            busy       <= 1'b0;
            serial_out <= 1'b0;
            word_done  <= 1'b0;
            frame_done <= 1'b0;
            if (start) begin
                state      <= SHIFT;
                addr       <= start_addr;
                words_left <= {1'b0, burst_len} + (LEN_W+1)'(1);
                shadow     <= mux_ord;
                bit_cnt    <= '0;
                addr_err   <= mux_invalid;
            end
        end else begin
            busy       <= 1'b1;
            serial_out <= shadow[0];
            word_done  <= last_bit;
            frame_done <= last_bit && last_word;
            if (last_bit) begin
                bit_cnt    <= '0;
                addr       <= next_addr;
                shadow     <= mux_ord;
                words_left <= words_left - (LEN_W+1)'(1);
                if (last_word) state <= IDLE;
            end else begin
                bit_cnt <= bit_cnt + DATA_W'(1);
                shadow  <= shadow >> 1;
            end
        end
    end

endmodule

// File: tb/tb_poci_burst_serializer.sv
// tb_poci_burst_serializer: queue-based reference model with per-cycle compare plus directed literal checks
module tb_poci_burst_serializer;

    localparam int W  = 8;
    localparam int N  = 59;
    localparam int AW = 8;
    localparam int LW = 4;

    logic          sclk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [LW-1:0] burst_len = '0;
    logic [7:0]    ra [1:N];
    logic [15:0]   rb [1:3];
    logic [N*W-1:0] flat_a;
    logic [47:0]   flat_b;
    logic          busy_a, so_a, wd_a, fd_a, err_a;
    logic          busy_b, so_b, wd_b, fd_b, err_b;
    logic          use_b = 1'b0;
    logic          chk_en = 1'b0;
    int            n_chk = 0;
    int            n_pass = 0;

    always #5 sclk = ~sclk;

    always_comb begin
        flat_a = '0;
        for (int i = 1; i <= N; i++) flat_a[(i-1)*W +: W] = ra[i];
        flat_b = '0;
        for (int i = 1; i <= 3; i++) flat_b[(i-1)*16 +: 16] = rb[i];
    end

    poci_burst_serializer dut_a (
        .sclk (sclk), .rst (rst), .regs_flat (flat_a), .start (start),
        .start_addr (start_addr), .burst_len (burst_len), .busy (busy_a),
        .serial_out (so_a), .word_done (wd_a), .frame_done (fd_a), .addr_err (err_a)
    );

    poci_burst_serializer #(.DATA_W (16), .NUM_REGS (3), .ADDR_W (AW), .LEN_W (LW), .LSB_FIRST (1'b0)) dut_b (
        .sclk (sclk), .rst (rst), .regs_flat (flat_b), .start (start),
        .start_addr (start_addr), .burst_len (burst_len), .busy (busy_b),
        .serial_out (so_b), .word_done (wd_b), .frame_done (fd_b), .addr_err (err_b)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: future output cycles of DUT A as a queue of {busy, bit, word_done, frame_done}
    typedef struct packed {logic b; logic s; logic w; logic f;} out_t;
    out_t q[$];
    out_t exp_o = '0;
    logic exp_err = 1'b0;
    logic m_acc;
    int   m_left, m_addr;

    function automatic logic m_valid(input int a);
        return a >= 1 && a <= N;
    endfunction

    task automatic push_word(input int a, input logic last);
        logic [7:0] v;
        v = m_valid(a) ? ra[a] : 8'h00;
        for (int i = 0; i < W; i++) q.push_back('{1'b1, v[i], i == W - 1, last && i == W - 1});
    endtask

    always @(posedge sclk) begin
        if (rst) begin
            q.delete();
            m_left  = 0;
            exp_err = 1'b0;
            exp_o   = '0;
        end else begin
            m_acc = start && q.size() == 0;
            exp_o = '0;
            if (q.size() > 0) exp_o = q.pop_front();
            if (exp_o.w && m_left > 0) begin
                m_addr = m_addr >= N ? 1 : m_addr + 1;
                m_left--;
                push_word(m_addr, m_left == 0);
            end
            if (m_acc) begin
                m_addr  = int'(start_addr);
                m_left  = int'(burst_len);
                exp_err = !m_valid(m_addr);
                push_word(m_addr, m_left == 0);
            end
        end
    end

    always @(negedge sclk)
        if (chk_en) chk("cycle", {busy_a, so_a, wd_a, fd_a, err_a}, {exp_o, exp_err});

    task automatic kick(input int a, input int l, input logic hold);
        @(negedge sclk);
        start      = 1'b1;
        start_addr = AW'(a);
        burst_len  = LW'(l);
        @(negedge sclk);
        start = hold;
    endtask

    // Sample i is the output after the (i+1)-th edge following the accepting edge
    task automatic capture(input int n, input int pulse_at, input int rst_at,
                           output logic [127:0] cap, output logic [127:0] bm,
                           output int nwd, output int nfd, output int fdpos);
        cap = '0; bm = '0; nwd = 0; nfd = 0; fdpos = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge sclk);
            cap[i] = use_b ? so_b : so_a;
            bm[i]  = use_b ? busy_b : busy_a;
            if (use_b ? wd_b : wd_a) nwd++;
            if (use_b ? fd_b : fd_a) begin nfd++; fdpos = i; end
            if (i == pulse_at) start = 1'b1;
            if (i == pulse_at + 1) start = 1'b0;
            if (i == rst_at) rst = 1'b1;
            if (i == rst_at + 1) rst = 1'b0;
        end
    endtask

    logic [127:0] cap, bm;
    int nwd, nfd, fdpos;

    initial begin
        for (int i = 1; i <= N; i++) ra[i] = 8'($urandom);
        for (int i = 1; i <= 3; i++) rb[i] = 16'($urandom);
        @(negedge sclk);
        chk_en = 1'b1;
        @(negedge sclk);
        chk("reset", {busy_a, so_a, wd_a, fd_a, err_a, busy_b, so_b, wd_b, fd_b, err_b}, 0);
        rst = 1'b0;

        ra[5] = 8'hA5;
        kick(5, 0, 1'b0);
        capture(12, -1, -1, cap, bm, nwd, nfd, fdpos);
        chk("single_bits", cap[7:0], 8'hA5);
        chk("single_busy", bm, 128'hFF);
        chk("single_wd", nwd, 1);
        chk("single_fd_pos", fdpos, 7);

        ra[58] = 8'h01; ra[59] = 8'h80; ra[1] = 8'hFF;
        kick(58, 2, 1'b0);
        capture(28, -1, -1, cap, bm, nwd, nfd, fdpos);
        chk("wrap_bits", cap[23:0], 24'hFF8001);
        chk("wrap_busy", bm, 128'hFFFFFF);
        chk("wrap_wd", nwd, 3);
        chk("wrap_fd", {nfd[7:0], fdpos[7:0]}, {8'd1, 8'd23});

        kick(0, 0, 1'b0);
        capture(10, -1, -1, cap, bm, nwd, nfd, fdpos);
        chk("addr0", {cap[7:0], bm[7:0], err_a}, {8'h00, 8'hFF, 1'b1});
        kick(60, 0, 1'b0);
        capture(10, -1, -1, cap, bm, nwd, nfd, fdpos);
        chk("addr60", {cap[7:0], bm[7:0], err_a}, {8'h00, 8'hFF, 1'b1});
        kick(5, 0, 1'b0);
        capture(10, -1, -1, cap, bm, nwd, nfd, fdpos);
        chk("err_clear", {cap[7:0], err_a}, {8'hA5, 1'b0});

        ra[10] = 8'h11; ra[11] = 8'h22; ra[12] = 8'h33; ra[13] = 8'h44;
        kick(10, 3, 1'b0);
        capture(14, -1, 11, cap, bm, nwd, nfd, fdpos);
        chk("abort_busy", bm, 128'hFFF);
        chk("abort_out", {cap[13:12], nfd[7:0], nwd[7:0]}, {2'b00, 8'd0, 8'd1});
        kick(10, 3, 1'b0);
        capture(36, -1, -1, cap, bm, nwd, nfd, fdpos);
        chk("after_abort", {cap[31:0], bm[35:0], nfd[7:0]}, {32'h44332211, 36'hFFFFFFFF, 8'd1});

        kick(20, 1, 1'b0);
        capture(20, 5, -1, cap, bm, nwd, nfd, fdpos);
        chk("start_busy_ignored", {bm[19:0], nfd[7:0]}, {20'hFFFF, 8'd1});

        kick(5, 0, 1'b1);
        capture(20, 8, -1, cap, bm, nwd, nfd, fdpos);
        chk("held_gap", bm[19:0], 20'h1FEFF);
        chk("held_bits", {cap[16:9], cap[7:0]}, {8'hA5, 8'hA5});

        @(negedge sclk); rst = 1'b1;
        @(negedge sclk); rst = 1'b0;
        use_b = 1'b1;
        rb[2] = 16'h8001;
        kick(2, 0, 1'b0);
        capture(20, -1, -1, cap, bm, nwd, nfd, fdpos);
        chk("b_msb_bits", {cap[15:0], bm[19:0], fdpos[7:0]}, {16'h8001, 20'hFFFF, 8'd15});
        rb[3] = 16'hC000; rb[1] = 16'h0003;
        kick(3, 1, 1'b0);
        capture(36, -1, -1, cap, bm, nwd, nfd, fdpos);
        chk("b_wrap_bits", cap[31:0], 32'hC0000003);
        chk("b_wrap_ctl", {bm[35:0], nwd[7:0], err_b}, {36'hFFFFFFFF, 8'd2, 1'b0});
        use_b = 1'b0;

        for (int c = 0; c < 4000; c++) begin
            @(negedge sclk);
            start      = $urandom_range(0, 7) == 0;
            start_addr = AW'($urandom_range(0, 63));
            burst_len  = LW'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) ra[$urandom_range(1, N)] = 8'($urandom);
            rst = $urandom_range(0, 499) == 0;
        end
        @(negedge sclk);
        start = 1'b0;
        rst   = 1'b0;
        repeat (300) @(negedge sclk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
